// File: rtl/picture_scanner_if.sv
// Pixel stream from the picture scanner to its consumer.
// Valid/ready handshake carrying {R,G,B} plus frame position tags.
interface picture_scanner_if;
  logic        pix_valid;
  logic        pix_ready;
  logic [23:0] pix_data;
  logic        pix_sof;
  logic        pix_eol;
  logic        pix_eof;

  modport master (output pix_valid, pix_data, pix_sof, pix_eol, pix_eof,
                  input  pix_ready);
  modport slave  (input  pix_valid, pix_data, pix_sof, pix_eol, pix_eof,
                  output pix_ready);
endinterface

// File: rtl/picture_scanner.sv
// Scans an IMG_W x IMG_H picture out of a synchronous-read memory in raster order.
// Reads are throttled so that reads in flight plus buffered pixels never exceed two.
module picture_scanner #(
  parameter int BASE_ADRS = 1792,
  parameter int IMG_W     = 16,
  parameter int IMG_H     = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              continuous,
  output logic [10:0]       picture_radrs,
  input  logic [23:0]       picture_data,
  picture_scanner_if.master pix,
  output logic              busy,
  output logic              frame_done
);
  localparam int DATA_W = 24;
  localparam int ADRS_W = 11;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int CNT_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [ADRS_W-1:0] BASE_A   = ADRS_W'(BASE_ADRS);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NPIX - 1);
  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(IMG_W - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } tag_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [COL_W-1:0]  col_q;
  logic [ADRS_W-1:0] radrs_q;
  logic              inflight_q;
  tag_t              inflight_tag_q;
  logic [1:0]        count_q;
  logic [1:0]        count_d;
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] fifo_data_q [2];
  tag_t              fifo_tag_q  [2];

  logic              pop;
  logic              issue;
  logic [2:0]        occ;
  logic [ADRS_W-1:0] issue_adrs;
  tag_t              issue_tag;
  tag_t              head_tag;

  // Occupancy counts the slot freed by this cycle's pop, which keeps one pixel per clk flowing.
  always_comb begin
    pop           = (count_q != 2'd0) && pix.pix_ready;
    occ           = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    issue         = (state_q == FETCH) && (occ < 3'd2);
    issue_adrs    = BASE_A + ADRS_W'(cnt_q);
    issue_tag.sof = (cnt_q == '0);
    issue_tag.eol = (col_q == LAST_COL);
    issue_tag.eof = (cnt_q == LAST_CNT);
    count_d       = count_q + 2'(inflight_q) - 2'(pop);
    head_tag      = fifo_tag_q[rd_ptr_q];
  end

  assign picture_radrs = issue ? issue_adrs : radrs_q;
  assign pix.pix_valid = (count_q != 2'd0);
  assign pix.pix_data  = pix.pix_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign pix.pix_sof   = pix.pix_valid & head_tag.sof;
  assign pix.pix_eol   = pix.pix_valid & head_tag.eol;
  assign pix.pix_eof   = pix.pix_valid & head_tag.eof;
  assign busy          = busy_q;
  assign frame_done    = done_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      col_q          <= '0;
      radrs_q        <= BASE_A;
      inflight_q     <= 1'b0;
      inflight_tag_q <= '0;
      count_q        <= 2'd0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= issue;
      count_q    <= count_d;
      if (issue) begin
        inflight_tag_q <= issue_tag;
        radrs_q        <= issue_adrs;
      end
      if (inflight_q) wr_ptr_q <= ~wr_ptr_q;
      if (pop)        rd_ptr_q <= ~rd_ptr_q;

      unique case (state_q)
        IDLE: begin
          if (start || continuous) begin
            state_q <= FETCH;
            cnt_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        FETCH: begin
          if (issue) begin
            if (cnt_q == LAST_CNT) begin
              state_q <= DRAIN;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
              col_q <= (col_q == LAST_COL) ? '0 : col_q + COL_W'(1);
            end
          end
        end
        DRAIN: begin
          // The eof pixel is the last one issued, so its acceptance empties the pipeline.
          if (pop && head_tag.eof) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Buffered pixel storage holds no control state and needs no reset.
  always_ff @(posedge clk) begin
    if (inflight_q) begin
      fifo_data_q[wr_ptr_q] <= picture_data;
      fifo_tag_q[wr_ptr_q]  <= inflight_tag_q;
    end
  end
endmodule

// File: tb/tb_picture_scanner.sv
// Scoreboard bench for picture_scanner: expected pixels are queued at stimulus time
// and a negedge monitor pops and compares every accepted pixel.
module tb_picture_scanner;
  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        continuous;
  logic [10:0] picture_radrs;
  logic [23:0] picture_data;
  logic        busy;
  logic        frame_done;

  picture_scanner_if pif ();

  picture_scanner #(.BASE_ADRS(1792), .IMG_W(16), .IMG_H(16)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .continuous   (continuous),
    .picture_radrs(picture_radrs),
    .picture_data (picture_data),
    .pix          (pif),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int acc_cnt = 0;
  int cyc = 0;
  int sof_cyc = 0;
  int eof_cyc = 0;
  int idle_run = 0;
  int max_gap = 0;
  int rdy_mode = 0;
  logic eof_pending = 1'b0;
  logic stall_prev = 1'b0;
  logic [26:0] held = '0;
  logic [26:0] exp_q[$];

  function automatic logic [23:0] pix_of(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, ~b, b ^ 8'h3C};
  endfunction

  // Memory model: one-clock read latency, address 1792+i holds pixel i.
  always @(posedge clk) begin
    if (picture_radrs >= 11'd1792) picture_data <= pix_of(int'(picture_radrs) - 1792);
    else                           picture_data <= 24'hBAD000;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    pif.pix_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       pif.pix_ready = 1'b0;
        1:       pif.pix_ready = 1'b1;
        default: pif.pix_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: frame_done bookkeeping, stall stability, scoreboard compare, idle gaps.
  initial begin
    logic [26:0] got;
    logic [26:0] exp;
    forever begin
      @(negedge clk);
      cyc++;
      got = {pif.pix_data, pif.pix_sof, pif.pix_eol, pif.pix_eof};
      if (frame_done) begin
        done_cnt++;
        check("done_after_eof", 32'(eof_pending), 32'd1);
        eof_pending = 1'b0;
      end
      if (resetn && stall_prev)
        check("stall_hold", {4'd0, pif.pix_valid, got}, {4'd0, 1'b1, held});
      stall_prev = resetn && pif.pix_valid && !pif.pix_ready;
      if (stall_prev) held = got;
      if (pif.pix_valid && pif.pix_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pixel actual=%0h required=none", got);
        end else begin
          exp = exp_q.pop_front();
          check("pixel", 32'(got), 32'(exp));
        end
        acc_cnt++;
        if (pif.pix_sof) sof_cyc = cyc;
        if (pif.pix_eof) begin
          eof_cyc = cyc;
          eof_pending = 1'b1;
        end
      end
      if (!busy) idle_run++;
      else begin
        if (idle_run > max_gap) max_gap = idle_run;
        idle_run = 0;
      end
    end
  end

  task automatic push_frames(input int n);
    for (int f = 0; f < n; f++)
      for (int i = 0; i < 256; i++)
        exp_q.push_back({pix_of(i), 1'(i == 0), 1'((i % 16) == 15), 1'(i == 255)});
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin @(negedge clk); #1; end
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (done_cnt < target && n < budget) begin @(negedge clk); #1; n++; end
    check(name, 32'(done_cnt), 32'(target));
  endtask

  task automatic wait_busy(input int budget, input string name);
    int n = 0;
    while (!busy && n < budget) begin @(negedge clk); #1; n++; end
    check(name, 32'(busy), 32'd1);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_valid"}, 32'(pif.pix_valid), 32'd0);
    check({name, "_data"},  32'(pif.pix_data), 32'd0);
    check({name, "_tags"},  32'({pif.pix_sof, pif.pix_eol, pif.pix_eof}), 32'd0);
    check({name, "_busy"},  32'(busy), 32'd0);
    check({name, "_done"},  32'(frame_done), 32'd0);
    check({name, "_radrs"}, 32'(picture_radrs), 32'd1792);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    int a0;
    int n;
    resetn = 1'b0; start = 1'b0; continuous = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1 resetn = 1'b1;

    // Single frame, ready held high: latency, order, tags, throughput.
    rdy_mode = 1;
    push_frames(1);
    d0 = done_cnt;
    pulse_start();
    @(negedge clk);
    check("lat_busy", 32'(busy), 32'd1);
    check("lat_c0", 32'(pif.pix_valid), 32'd0);
    @(negedge clk);
    check("lat_c1", 32'(pif.pix_valid), 32'd0);
    @(negedge clk);
    check("lat_c2", 32'(pif.pix_valid), 32'd1);
    wait_done(d0 + 1, 600, "a_done");
    idle_cycles(10);
    check("a_one_done", 32'(done_cnt), 32'(d0 + 1));
    check("a_queue_empty", 32'(exp_q.size()), 32'd0);
    check("a_throughput", 32'(eof_cyc - sof_cyc), 32'd255);

    // Random ready with a start pulse while busy.
    rdy_mode = 2;
    push_frames(1);
    d0 = done_cnt;
    pulse_start();
    idle_cycles(50);
    pulse_start();
    wait_done(d0 + 1, 3000, "b_done");
    idle_cycles(30);
    check("b_one_done", 32'(done_cnt), 32'(d0 + 1));
    check("b_idle", 32'(busy), 32'd0);
    check("b_queue_empty", 32'(exp_q.size()), 32'd0);

    // Ready low for 20 clocks after start.
    rdy_mode = 0;
    push_frames(1);
    d0 = done_cnt;
    pulse_start();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("c_outstanding", 32'(picture_radrs <= 11'd1793), 32'd1);
      if (k >= 2) begin
        check("c_valid", 32'(pif.pix_valid), 32'd1);
        check("c_pix0", {7'd0, pif.pix_data, pif.pix_sof}, {7'd0, pix_of(0), 1'b1});
      end
    end
    rdy_mode = 1;
    wait_done(d0 + 1, 600, "c_done");
    idle_cycles(5);
    check("c_queue_empty", 32'(exp_q.size()), 32'd0);

    // Continuous mode for three frames.
    push_frames(3);
    d0 = done_cnt;
    @(posedge clk); #1 continuous = 1'b1;
    wait_busy(20, "d_busy0");
    @(posedge clk);
    max_gap = 0; idle_run = 0;
    wait_done(d0 + 2, 1500, "d_done2");
    wait_busy(20, "d_busy2");
    @(posedge clk); #1 continuous = 1'b0;
    wait_done(d0 + 3, 800, "d_done3");
    idle_cycles(20);
    check("d_three_done", 32'(done_cnt), 32'(d0 + 3));
    check("d_gap_le1", 32'(max_gap <= 1), 32'd1);
    check("d_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame near pixel 100, then a fresh frame.
    push_frames(1);
    d0 = done_cnt;
    a0 = acc_cnt;
    pulse_start();
    n = 0;
    while (acc_cnt < a0 + 100 && n < 400) begin @(negedge clk); #1; n++; end
    check("e_reach100", 32'(acc_cnt >= a0 + 100), 32'd1);
    @(posedge clk); #1 resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("e_reset");
    exp_q.delete();
    @(posedge clk); #1 resetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("e_no_stale", 32'({pif.pix_valid, busy}), 32'd0);
    end
    check("e_no_done", 32'(done_cnt), 32'(d0));
    push_frames(1);
    pulse_start();
    wait_done(d0 + 1, 600, "e_done");
    idle_cycles(5);
    check("e_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
